// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator CPU control path.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC_RD, S_EXEC_ALU,
    S_EXEC_WR, S_EXEC_JMP, S_EXEC_INC, S_EXEC_CLR, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDAC  = 4'd1;
  localparam logic [3:0] OP_STAC  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_JMPZ  = 4'd6;
  localparam logic [3:0] OP_INCAC = 4'd7;
  localparam logic [3:0] OP_CLAC  = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_IR   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_MEM  = 3'd5;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_ZERO = 2'd3;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory signal bundle; master is the sequencer side.
interface control_sequencer_if #(parameter int OPW = 4, parameter int BSW = 3);
  logic [OPW-1:0] opcode;
  logic           z_flag;
  logic           mem_ready;
  logic           pc_write, pc_inc, ar_write, ir_write, dr_write;
  logic           ac_write, ac_inc;
  logic [BSW-1:0] bus_sel;
  logic [1:0]     alu_op;
  logic           mem_rd, mem_wr, halted;

  modport master (
    input  opcode, z_flag, mem_ready,
    output pc_write, pc_inc, ar_write, ir_write, dr_write, ac_write, ac_inc,
           bus_sel, alu_op, mem_rd, mem_wr, halted
  );

  modport slave (
    output opcode, z_flag, mem_ready,
    input  pc_write, pc_inc, ar_write, ir_write, dr_write, ac_write, ac_inc,
           bus_sel, alu_op, mem_rd, mem_wr, halted
  );
endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode decode: DECODE successor state and EXEC_ALU alu_op.
module opcode_decoder
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  output state_t         next_state,
  output logic [1:0]     alu_op
);

  always_comb begin
    next_state = S_FETCH1;
    alu_op     = ALU_PASS;
    case (opcode)
      OP_LDAC:  next_state = S_EXEC_RD;
      OP_ADD:   begin next_state = S_EXEC_RD; alu_op = ALU_ADD; end
      OP_SUB:   begin next_state = S_EXEC_RD; alu_op = ALU_SUB; end
      OP_STAC:  next_state = S_EXEC_WR;
      OP_JMP:   next_state = S_EXEC_JMP;
      OP_JMPZ:  next_state = z_flag ? S_EXEC_JMP : S_FETCH1;
      OP_INCAC: next_state = S_EXEC_INC;
      OP_CLAC:  next_state = S_EXEC_CLR;
      OP_HALT:  next_state = S_HALT;
      // NOP and the unassigned opcodes all fall back to fetching
      default:  next_state = S_FETCH1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Define INSTR_COUNT_EN to add the instr_count output (instructions decoded).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int BSW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  control_sequencer_if.master cs
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]         instr_count
`endif
);

  state_t     state, state_nx, dec_nx;
  logic [1:0] dec_alu, alu_op;
  logic [2:0] bus_sel;
  logic       pc_write, pc_inc, ar_write, ir_write, dr_write;
  logic       ac_write, ac_inc, mem_rd, mem_wr, halted;

  opcode_decoder #(.OPW(OPW)) u_dec (
    .opcode     (cs.opcode),
    .z_flag     (cs.z_flag),
    .next_state (dec_nx),
    .alu_op     (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_write = 1'b0; pc_inc   = 1'b0; ar_write = 1'b0;
    ir_write = 1'b0; dr_write = 1'b0;
    ac_write = 1'b0; ac_inc   = 1'b0;
    mem_rd   = 1'b0; mem_wr   = 1'b0; halted   = 1'b0;
    bus_sel  = BUS_NONE;
    alu_op   = ALU_PASS;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH1;
      S_FETCH1: begin bus_sel = BUS_PC; ar_write = 1'b1; state_nx = S_FETCH2; end
      S_FETCH2: begin
        mem_rd  = 1'b1;
        bus_sel = BUS_MEM;
        if (cs.mem_ready) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_DECODE;
        end
      end
      // AR picks up the operand address for every opcode; unused ones ignore it
      S_DECODE: begin bus_sel = BUS_IR; ar_write = 1'b1; state_nx = dec_nx; end
      S_EXEC_RD: begin
        mem_rd  = 1'b1;
        bus_sel = BUS_MEM;
        if (cs.mem_ready) begin
          dr_write = 1'b1;
          state_nx = S_EXEC_ALU;
        end
      end
      S_EXEC_ALU: begin
        bus_sel  = BUS_DR;
        ac_write = 1'b1;
        alu_op   = dec_alu;
        state_nx = S_FETCH1;
      end
      S_EXEC_WR: begin
        mem_wr  = 1'b1;
        bus_sel = BUS_AC;
        if (cs.mem_ready) state_nx = S_FETCH1;
      end
      S_EXEC_JMP: begin bus_sel = BUS_IR; pc_write = 1'b1; state_nx = S_FETCH1; end
      S_EXEC_INC: begin ac_inc = 1'b1; state_nx = S_FETCH1; end
      S_EXEC_CLR: begin alu_op = ALU_ZERO; ac_write = 1'b1; state_nx = S_FETCH1; end
      S_HALT:     halted = 1'b1;
      default:    state_nx = S_IDLE;
    endcase
  end

  assign cs.pc_write = pc_write;
  assign cs.pc_inc   = pc_inc;
  assign cs.ar_write = ar_write;
  assign cs.ir_write = ir_write;
  assign cs.dr_write = dr_write;
  assign cs.ac_write = ac_write;
  assign cs.ac_inc   = ac_inc;
  assign cs.bus_sel  = BSW'(bus_sel);
  assign cs.alu_op   = alu_op;
  assign cs.mem_rd   = mem_rd;
  assign cs.mem_wr   = mem_wr;
  assign cs.halted   = halted;

`ifdef INSTR_COUNT_EN
  // ir_write is already qualified by mem_ready, so this counts DECODE entries
  always_ff @(posedge clk) begin
    if (rst)           instr_count <= 16'd0;
    else if (ir_write) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed sequences plus random programs run on a
// bench-side datapath and compared with an instruction-level interpreter.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  control_sequencer_if #(.OPW(4), .BSW(3)) cs ();

  logic        auto_mode, man_ready, auto_ready, man_z;
  logic [3:0]  man_op;
  logic [15:0] dp_pc, dp_ar, dp_ir, dp_dr, dp_ac, bus;
  logic [15:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  int          wq[$];
  int          n_chk = 0, n_err = 0;
`ifdef INSTR_COUNT_EN
  logic [15:0] icnt;
`endif

  assign cs.mem_ready = auto_mode ? auto_ready : man_ready;
  assign cs.opcode    = auto_mode ? dp_ir[15:12] : man_op;
  assign cs.z_flag    = auto_mode ? (dp_ac == 16'd0) : man_z;

  control_sequencer #(.OPW(4), .BSW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cs    (cs)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count (icnt)
`endif
  );

  logic [14:0] outs;
  assign outs = {cs.pc_write, cs.pc_inc, cs.ar_write, cs.ir_write, cs.dr_write,
                 cs.ac_write, cs.ac_inc, cs.bus_sel, cs.alu_op,
                 cs.mem_rd, cs.mem_wr, cs.halted};

  localparam logic [14:0] PCW = 15'h4000, PCI = 15'h2000, ARW = 15'h1000;
  localparam logic [14:0] IRW = 15'h0800, DRW = 15'h0400, ACW = 15'h0200;
  localparam logic [14:0] MRD = 15'h0004, MWR = 15'h0002, HLT = 15'h0001;

  function automatic logic [14:0] bs(input int b);
    return 15'(b) << 5;
  endfunction

  function automatic logic [14:0] alu(input int a);
    return 15'(a) << 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register datapath and memory driven by the sequencer's enables
  always_comb begin
    bus = 16'd0;
    case (cs.bus_sel)
      3'd1: bus = dp_pc;
      3'd2: bus = {4'd0, dp_ir[11:0]};
      3'd3: bus = dp_dr;
      3'd4: bus = dp_ac;
      3'd5: bus = mem[dp_ar[7:0]];
      default: bus = 16'd0;
    endcase
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (cs.mem_wr && cs.mem_ready) mem[dp_ar[7:0]] <= bus;
    if (rst) begin
      dp_pc <= '0; dp_ar <= '0; dp_ir <= '0; dp_dr <= '0; dp_ac <= '0;
    end else begin
      if (cs.ar_write) dp_ar <= bus;
      if (cs.pc_write) dp_pc <= bus;
      else if (cs.pc_inc) dp_pc <= dp_pc + 16'd1;
      if (cs.ir_write) dp_ir <= bus;
      if (cs.dr_write) dp_dr <= bus;
      if (cs.ac_write) begin
        case (cs.alu_op)
          2'd0: dp_ac <= bus;
          2'd1: dp_ac <= dp_ac + bus;
          2'd2: dp_ac <= dp_ac - bus;
          default: dp_ac <= 16'd0;
        endcase
      end else if (cs.ac_inc) dp_ac <= dp_ac + 16'd1;
    end
  end

  // Memory responder: each request takes the next wait count from wq
  initial begin
    bit busy = 1'b0;
    int wcur = 0;
    auto_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_mode || !(cs.mem_rd || cs.mem_wr)) begin
        busy = 1'b0;
        auto_ready = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcur = (wq.size() != 0) ? wq.pop_front() : 0;
        end
        if (wcur == 0) begin
          auto_ready = 1'b1;
          busy = 1'b0;
        end else begin
          auto_ready = 1'b0;
          wcur--;
        end
      end
    end
  end

  // Per-cycle invariants: exclusive enables, requests held until ready
  initial begin
    bit hold_rd = 1'b0, hold_wr = 1'b0;
    forever begin
      @(negedge clk);
      chk("excl_enables", 32'({cs.mem_rd & cs.mem_wr, cs.pc_write & cs.pc_inc,
                               cs.ac_write & cs.ac_inc}), 32'd0);
      if (hold_rd) chk("rd_held", 32'(cs.mem_rd), 32'd1);
      if (hold_wr) chk("wr_held", 32'(cs.mem_wr), 32'd1);
      hold_rd = cs.mem_rd && !cs.mem_ready && !rst;
      hold_wr = cs.mem_wr && !cs.mem_ready && !rst;
    end
  end

  task automatic run_prog();
    logic [15:0] img [256];
    int          waits [64];
    int          ops [14] = '{0, 1, 1, 2, 3, 3, 4, 5, 6, 6, 7, 8, 9, 12};
    logic [15:0] pc, ac, ir;
    logic [11:0] a;
    int          cyc, wi, ninstr, n, diffs, tgt, op;

    for (int i = 0; i < 256; i++) img[i] = (i < 128) ? 16'hF000 : 16'($urandom);
    for (int i = 0; i < 23; i++) begin
      op = ops[$urandom_range(0, 13)];
      a  = 12'($urandom_range(0, 4095));
      if (op >= 1 && op <= 4) a = 12'(128 + $urandom_range(0, 15));
      if (op == 5 || op == 6) begin
        tgt = i + 1 + $urandom_range(0, 3);
        a = 12'((tgt > 23) ? 23 : tgt);
      end
      img[i] = {4'(op), a};
    end
    for (int i = 0; i < 64; i++) waits[i] = $urandom_range(0, 3);
    wq = {};
    for (int i = 0; i < 64; i++) wq.push_back(waits[i]);

    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = img[i];
      step();
    end
    ld_en = 1'b0;

    // Instruction-level interpreter: architectural result and total cycles
    pc = 0; ac = 0; cyc = 0; wi = 0; ninstr = 0;
    for (int s = 0; s < 100; s++) begin
      ir = img[pc[7:0]];
      pc = pc + 16'd1;
      cyc += 3 + waits[wi++];
      ninstr++;
      a = ir[11:0];
      case (ir[15:12])
        4'd1: begin ac = img[a[7:0]];      cyc += 2 + waits[wi++]; end
        4'd3: begin ac = ac + img[a[7:0]]; cyc += 2 + waits[wi++]; end
        4'd4: begin ac = ac - img[a[7:0]]; cyc += 2 + waits[wi++]; end
        4'd2: begin img[a[7:0]] = ac;      cyc += 1 + waits[wi++]; end
        4'd5: begin pc = {4'd0, a}; cyc += 1; end
        4'd6: if (ac == 16'd0) begin pc = {4'd0, a}; cyc += 1; end
        4'd7: begin ac = ac + 16'd1; cyc += 1; end
        4'd8: begin ac = 16'd0; cyc += 1; end
        default: ;
      endcase
      if (ir[15:12] == 4'd15) break;
    end

    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (n < 3000) begin
      step();
      n++;
      if (cs.halted) break;
    end
    chk("prog_halted", 32'(cs.halted), 32'd1);
    chk("prog_cycles", 32'(n), 32'(cyc));
    chk("prog_ac", 32'(dp_ac), 32'(ac));
    chk("prog_pc", 32'(dp_pc), 32'(pc));
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) diffs++;
    chk("prog_mem_diffs", 32'(diffs), 32'd0);
`ifdef INSTR_COUNT_EN
    chk("prog_icnt", 32'(icnt), 32'(ninstr));
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; auto_mode = 1'b0; man_ready = 1'b1;
    man_op = 4'd0; man_z = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset dominates start; then IDLE -> FETCH1
    step(); step();
    chk("reset_outs", 32'(outs), 32'd0);
`ifdef INSTR_COUNT_EN
    chk("reset_icnt", 32'(icnt), 32'd0);
`endif
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle", 32'(outs), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fetch1", 32'(outs), 32'(ARW | bs(1)));

    // LDAC, no wait states
    man_op = 4'd1;
    step(); chk("ldac_fetch2", 32'(outs), 32'(MRD | bs(5) | IRW | PCI));
    step(); chk("ldac_decode", 32'(outs), 32'(ARW | bs(2)));
    step(); chk("ldac_exec_rd", 32'(outs), 32'(MRD | bs(5) | DRW));
    step(); chk("ldac_exec_alu", 32'(outs), 32'(bs(3) | ACW | alu(0)));
    step(); chk("ldac_fetch1", 32'(outs), 32'(ARW | bs(1)));

    // Fetch with three wait states, then JMPZ not taken
    man_op = 4'd6; man_z = 1'b0; man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("fetch2_wait", 32'(outs), 32'(MRD | bs(5)));
    end
    man_ready = 1'b1;
    #1 chk("fetch2_ready", 32'(outs), 32'(MRD | bs(5) | IRW | PCI));
    step(); chk("jmpz0_decode", 32'(outs), 32'(ARW | bs(2)));
    step(); chk("jmpz0_fetch1", 32'(outs), 32'(ARW | bs(1)));

    // JMPZ taken
    man_z = 1'b1;
    step(); step();
    step(); chk("jmpz1_exec", 32'(outs), 32'(PCW | bs(2)));
    step(); chk("jmpz1_fetch1", 32'(outs), 32'(ARW | bs(1)));

    // STAC with two wait states
    man_op = 4'd2; man_z = 1'b0;
    step(); step();
    man_ready = 1'b0;
    step(); chk("stac_wait", 32'(outs), 32'(MWR | bs(4)));
    step(); chk("stac_wait", 32'(outs), 32'(MWR | bs(4)));
    man_ready = 1'b1;
    #1 chk("stac_ready", 32'(outs), 32'(MWR | bs(4)));
    step(); chk("stac_fetch1", 32'(outs), 32'(ARW | bs(1)));

    // HALT ignores start until reset
    man_op = 4'd15;
    step(); step();
    step(); chk("halt", 32'(outs), 32'(HLT));
    for (int i = 0; i < 100; i++) begin
      start = 1'($urandom_range(0, 1));
      step();
      chk("halt_hold", 32'(outs), 32'(HLT));
    end
    start = 1'b0;
`ifdef INSTR_COUNT_EN
    chk("icnt_halt", 32'(icnt), 32'd5);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_reset", 32'(outs), 32'd0);

    // Reset during a stalled operand read
    start = 1'b1;
    step();
    start = 1'b0; man_op = 4'd1;
    step(); step();
    man_ready = 1'b0;
    step(); chk("rd_stall", 32'(outs), 32'(MRD | bs(5)));
    rst = 1'b1;
    step(); chk("rst_mid_rd", 32'(outs), 32'd0);
`ifdef INSTR_COUNT_EN
    chk("rst_mid_icnt", 32'(icnt), 32'd0);
`endif
    rst = 1'b0; man_ready = 1'b1;
    step(); chk("idle_after_rst", 32'(outs), 32'd0);

    // Random programs on the bench datapath
    auto_mode = 1'b1;
    for (int p = 0; p < 4; p++) run_prog();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
